// File: rtl/seq_shift_if.sv
// seq_shift_if: controller-side bus for seq_shift_unit; serial_in exists only with SEQ_SHIFT_SERIAL_IN_EN.
interface seq_shift_if #(
  parameter int W  = 8,
  parameter int AW = 3
);
  logic          start;
  logic [W-1:0]  load_data;
  logic [AW-1:0] amount;
  logic [2:0]    op;
`ifdef SEQ_SHIFT_SERIAL_IN_EN
  logic          serial_in;
`endif
  logic [W-1:0]  out;
  logic          busy;
  logic          done;
  logic          carry;
`ifdef SEQ_SHIFT_SERIAL_IN_EN
  modport master (output start, load_data, amount, op, serial_in, input out, busy, done, carry);
  modport slave  (input start, load_data, amount, op, serial_in, output out, busy, done, carry);
`else
  modport master (output start, load_data, amount, op, input out, busy, done, carry);
  modport slave  (input start, load_data, amount, op, output out, busy, done, carry);
`endif
endinterface

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shift/rotate unit, one bit step per clock with busy/done handshake.
// SEQ_SHIFT_SERIAL_IN_EN feeds serial_in as the LSL/LSR fill bit; otherwise fill is 0.
module seq_shift_unit #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input logic        clk,
  input logic        reset,
  seq_shift_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  out_q, out_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic          carry_q, carry_d;
  logic          fill;
`ifdef SEQ_SHIFT_SERIAL_IN_EN
  assign fill = bus.serial_in;
`else
  assign fill = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      carry_q <= carry_d;
    end
  end
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    carry_d = carry_q;
    if (state_q != SHIFT && bus.start) begin
      out_d   = bus.load_data;
      cnt_d   = bus.amount;
      op_d    = bus.op;
      carry_d = 1'b0;
      state_d = (bus.amount != '0) ? SHIFT : DONE;
    end else if (state_q == SHIFT) begin
      cnt_d   = cnt_q - 1'b1;
      state_d = (cnt_q == AW'(1)) ? DONE : SHIFT;
      case (op_q)
        3'b000: begin carry_d = out_q[W-1]; out_d = {out_q[W-2:0], fill};       end
        3'b001: begin carry_d = out_q[0];   out_d = {fill, out_q[W-1:1]};       end
        3'b010: begin carry_d = out_q[0];   out_d = {out_q[W-1], out_q[W-1:1]}; end
        3'b011: begin carry_d = out_q[W-1]; out_d = {out_q[W-2:0], out_q[W-1]}; end
        3'b100: begin carry_d = out_q[0];   out_d = {out_q[0], out_q[W-1:1]};   end
        default: ;
      endcase
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  assign bus.out   = out_q;
  assign bus.carry = carry_q;
  assign bus.busy  = (state_q == SHIFT);
  assign bus.done  = (state_q == DONE);
endmodule
